// File: rtl/sonar_pkg.sv
// Shared constants for the sonar serial link: ASCII frame characters,
// receiver state encodings and default bit timing (50 MHz / 115200 baud).
package sonar_pkg;

  localparam int BIT_TICKS_DEF  = 434;
  localparam int HALF_TICKS_DEF = 217;

  localparam logic [6:0] ASC_0    = 7'h30;
  localparam logic [6:0] ASC_9    = 7'h39;
  localparam logic [6:0] ASC_VIRG = 7'h2C;
  localparam logic [6:0] ASC_CERQ = 7'h23;

  typedef enum logic [3:0] {
    RX_IDLE      = 4'd0,
    RX_START     = 4'd1,
    RX_DATA      = 4'd2,
    RX_PARITY    = 4'd3,
    RX_STOP1     = 4'd4,
    RX_STOP2     = 4'd5,
    RX_WAIT_HIGH = 4'd6
  } rx_state_t;

endpackage

// File: rtl/rx_serial_7e2.sv
// 7-bit, even-parity, 2-stop-bit serial receiver with a 2-FF input synchroniser.
// Flags a received character (pronto_char) or a parity/framing error (erro_char) for one cycle.
module rx_serial_7e2
  import sonar_pkg::*;
#(
  parameter int BIT_TICKS  = BIT_TICKS_DEF,
  parameter int HALF_TICKS = HALF_TICKS_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  output logic [6:0] dado,
  output logic       pronto_char,
  output logic       erro_char,
  output logic [3:0] db_estado
);

  localparam logic [8:0] BIT_LOAD  = 9'(BIT_TICKS - 1);
  localparam logic [8:0] HALF_LOAD = 9'(HALF_TICKS - 1);

  rx_state_t  state_reg, state_next;
  logic [8:0] cnt_reg, cnt_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [6:0] dado_reg, dado_next;
  logic       par_err_reg, par_err_next;
  logic       pronto_char_reg, pronto_char_next;
  logic       erro_char_reg, erro_char_next;
  logic       sync1_reg, sync2_reg, prev_reg;
  logic       rx, tick;

  assign rx   = sync2_reg;
  assign tick = (cnt_reg == 9'd0);

  // Synchroniser and edge-detect history reset to the idle-high line level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_reg       <= 1'b1;
      sync2_reg       <= 1'b1;
      prev_reg        <= 1'b1;
      state_reg       <= RX_IDLE;
      cnt_reg         <= 9'd0;
      bit_cnt_reg     <= 3'd0;
      dado_reg        <= 7'd0;
      par_err_reg     <= 1'b0;
      pronto_char_reg <= 1'b0;
      erro_char_reg   <= 1'b0;
    end else begin
      sync1_reg       <= entrada_serial;
      sync2_reg       <= sync1_reg;
      prev_reg        <= sync2_reg;
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      bit_cnt_reg     <= bit_cnt_next;
      dado_reg        <= dado_next;
      par_err_reg     <= par_err_next;
      pronto_char_reg <= pronto_char_next;
      erro_char_reg   <= erro_char_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    cnt_next         = tick ? cnt_reg : cnt_reg - 9'd1;
    bit_cnt_next     = bit_cnt_reg;
    dado_next        = dado_reg;
    par_err_next     = par_err_reg;
    pronto_char_next = 1'b0;
    erro_char_next   = 1'b0;
    case (state_reg)
      RX_IDLE: begin
        if (prev_reg && !rx) begin
          state_next = RX_START;
          cnt_next   = HALF_LOAD;
        end
      end
      RX_START: begin
        if (tick) begin
          if (!rx) begin
            state_next   = RX_DATA;
            cnt_next     = BIT_LOAD;
            bit_cnt_next = 3'd0;
          end else begin
            state_next = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          dado_next    = {rx, dado_reg[6:1]};
          cnt_next     = BIT_LOAD;
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd6) state_next = RX_PARITY;
        end
      end
      RX_PARITY: begin
        if (tick) begin
          par_err_next = ^{dado_reg, rx};
          cnt_next     = BIT_LOAD;
          state_next   = RX_STOP1;
        end
      end
      RX_STOP1: begin
        if (tick) begin
          if (rx) begin
            state_next = RX_STOP2;
            cnt_next   = BIT_LOAD;
          end else begin
            erro_char_next = 1'b1;
            state_next     = RX_WAIT_HIGH;
          end
        end
      end
      RX_STOP2: begin
        if (tick) begin
          if (rx) begin
            pronto_char_next = !par_err_reg;
            erro_char_next   = par_err_reg;
            state_next       = RX_IDLE;
          end else begin
            erro_char_next = 1'b1;
            state_next     = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        if (rx) state_next = RX_IDLE;
      end
      default: state_next = RX_IDLE;
    endcase
  end

  assign dado        = dado_reg;
  assign pronto_char = pronto_char_reg;
  assign erro_char   = erro_char_reg;
  assign db_estado   = state_reg;

endmodule

// File: rtl/sonar_frame_rx.sv
// Receives sonar frames "A2A1A0,D2D1D0#" and publishes angle/distance as 3-digit BCD.
// After any error the parser stays silent until a '#' realigns it to a frame start.
module sonar_frame_rx
  import sonar_pkg::*;
#(
  parameter int BIT_TICKS  = BIT_TICKS_DEF,
  parameter int HALF_TICKS = HALF_TICKS_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        entrada_serial,
  output logic [11:0] angulo,
  output logic [11:0] distancia,
  output logic        pronto,
  output logic        erro,
  output logic [3:0]  db_estado_rx,
  output logic [3:0]  db_estado_parser
);

  logic [6:0] dado;
  logic       pronto_char, erro_char;

  rx_serial_7e2 #(
    .BIT_TICKS (BIT_TICKS),
    .HALF_TICKS(HALF_TICKS)
  ) u_rx (
    .clock         (clock),
    .reset         (reset),
    .entrada_serial(entrada_serial),
    .dado          (dado),
    .pronto_char   (pronto_char),
    .erro_char     (erro_char),
    .db_estado     (db_estado_rx)
  );

  logic [2:0]  pos_reg, pos_next;
  logic        sync_reg, sync_next;
  logic [11:0] ang_tmp_reg, ang_tmp_next;
  logic [11:0] dist_tmp_reg, dist_tmp_next;
  logic [11:0] angulo_reg, angulo_next;
  logic [11:0] distancia_reg, distancia_next;
  logic        pronto_reg, pronto_next;
  logic        erro_reg, erro_next;
  logic        char_ok;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pos_reg       <= 3'd0;
      sync_reg      <= 1'b0;
      ang_tmp_reg   <= 12'h000;
      dist_tmp_reg  <= 12'h000;
      angulo_reg    <= 12'h000;
      distancia_reg <= 12'h000;
      pronto_reg    <= 1'b0;
      erro_reg      <= 1'b0;
    end else begin
      pos_reg       <= pos_next;
      sync_reg      <= sync_next;
      ang_tmp_reg   <= ang_tmp_next;
      dist_tmp_reg  <= dist_tmp_next;
      angulo_reg    <= angulo_next;
      distancia_reg <= distancia_next;
      pronto_reg    <= pronto_next;
      erro_reg      <= erro_next;
    end
  end

  always_comb begin
    pos_next       = pos_reg;
    sync_next      = sync_reg;
    ang_tmp_next   = ang_tmp_reg;
    dist_tmp_next  = dist_tmp_reg;
    angulo_next    = angulo_reg;
    distancia_next = distancia_reg;
    pronto_next    = 1'b0;
    erro_next      = 1'b0;
    case (pos_reg)
      3'd3:    char_ok = (dado == ASC_VIRG);
      3'd7:    char_ok = (dado == ASC_CERQ);
      default: char_ok = (dado >= ASC_0) && (dado <= ASC_9);
    endcase
    if (sync_reg) begin
      if (pronto_char && dado == ASC_CERQ) begin
        sync_next = 1'b0;
        pos_next  = 3'd0;
      end
    end else if (erro_char || (pronto_char && !char_ok)) begin
      erro_next     = 1'b1;
      sync_next     = 1'b1;
      pos_next      = 3'd0;
      ang_tmp_next  = 12'h000;
      dist_tmp_next = 12'h000;
    end else if (pronto_char) begin
      if (pos_reg == 3'd7) begin
        angulo_next    = ang_tmp_reg;
        distancia_next = dist_tmp_reg;
        pronto_next    = 1'b1;
        pos_next       = 3'd0;
      end else begin
        pos_next = pos_reg + 3'd1;
        // Digits arrive hundreds first, so shifting left leaves units in [3:0].
        if (pos_reg < 3'd3) ang_tmp_next = {ang_tmp_reg[7:0], dado[3:0]};
        else if (pos_reg > 3'd3) dist_tmp_next = {dist_tmp_reg[7:0], dado[3:0]};
      end
    end
  end

  assign angulo           = angulo_reg;
  assign distancia        = distancia_reg;
  assign pronto           = pronto_reg;
  assign erro             = erro_reg;
  assign db_estado_parser = {sync_reg, pos_reg};

endmodule

// File: tb/tb_sonar_frame_rx.sv
// Directed bench for sonar_frame_rx: clean, parity, format, glitch/break,
// back-to-back and mid-frame reset scenarios at a shortened bit time.
module tb_sonar_frame_rx;

  localparam int BT = 40;
  localparam int HT = 20;

  logic        clk;
  logic        rst_n;
  logic        line;
  logic [11:0] angulo, distancia;
  logic        pronto, erro;
  logic [3:0]  db_estado_rx, db_estado_parser;

  int checks = 0;
  int errors = 0;
  int pronto_cnt = 0;
  int erro_cnt = 0;
  int overlap_cnt = 0;
  int p0, e0;

  sonar_frame_rx #(
    .BIT_TICKS (BT),
    .HALF_TICKS(HT)
  ) dut (
    .clock           (clk),
    .reset           (rst_n),
    .entrada_serial  (line),
    .angulo          (angulo),
    .distancia       (distancia),
    .pronto          (pronto),
    .erro            (erro),
    .db_estado_rx    (db_estado_rx),
    .db_estado_parser(db_estado_parser)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pronto) pronto_cnt++;
    if (erro) erro_cnt++;
    if (pronto && erro) overlap_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-18s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_bit(input logic b);
    line = b;
    repeat (BT) @(negedge clk);
  endtask

  task automatic send_char(input logic [6:0] c, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 7; i++) send_bit(c[i]);
    send_bit((^c) ^ bad_par);
    send_bit(1'b1);
    send_bit(1'b1);
  endtask

  task automatic send_str(input string s);
    byte b;
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      send_char(b[6:0], 1'b0);
    end
  endtask

  task automatic mark();
    p0 = pronto_cnt;
    e0 = erro_cnt;
  endtask

  initial begin
    line  = 1'b1;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_angulo", angulo, 12'h000);
    check("rst_distancia", distancia, 12'h000);
    check("rst_pronto", pronto, 0);
    check("rst_erro", erro, 0);
    check("rst_estado_rx", db_estado_rx, 4'h0);
    check("rst_estado_parser", db_estado_parser, 4'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Clean frame
    mark();
    send_str("045,123#");
    repeat (5) @(negedge clk);
    check("clean_pronto", pronto_cnt - p0, 1);
    check("clean_erro", erro_cnt - e0, 0);
    check("clean_angulo", angulo, 12'h045);
    check("clean_distancia", distancia, 12'h123);
    check("clean_parser", db_estado_parser, 4'h0);

    // Parity error on the '2' at pos 5
    mark();
    send_str("090,0");
    send_char(7'h32, 1'b1);
    repeat (5) @(negedge clk);
    check("par_erro", erro_cnt - e0, 1);
    check("par_pronto", pronto_cnt - p0, 0);
    check("par_angulo_hold", angulo, 12'h045);
    check("par_dist_hold", distancia, 12'h123);
    check("par_sync_flag", db_estado_parser[3], 1);
    send_str("0#");
    check("par_resync", db_estado_parser, 4'h0);
    check("par_resync_pronto", pronto_cnt - p0, 0);
    send_str("090,020#");
    repeat (5) @(negedge clk);
    check("par_next_pronto", pronto_cnt - p0, 1);
    check("par_next_erro", erro_cnt - e0, 1);
    check("par_next_angulo", angulo, 12'h090);
    check("par_next_dist", distancia, 12'h020);

    // Bad format: ',' at pos 2
    mark();
    send_str("12,");
    repeat (5) @(negedge clk);
    check("fmt_erro_at_comma", erro_cnt - e0, 1);
    send_str("0345#");
    check("fmt_erro_total", erro_cnt - e0, 1);
    check("fmt_pronto", pronto_cnt - p0, 0);
    check("fmt_angulo_hold", angulo, 12'h090);
    send_str("180,999#");
    repeat (5) @(negedge clk);
    check("fmt_next_pronto", pronto_cnt - p0, 1);
    check("fmt_next_angulo", angulo, 12'h180);
    check("fmt_next_dist", distancia, 12'h999);

    // Short low glitch: no character, no error
    mark();
    line = 1'b0;
    repeat (10) @(negedge clk);
    line = 1'b1;
    repeat (2 * BT) @(negedge clk);
    check("glitch_erro", erro_cnt - e0, 0);
    check("glitch_pronto", pronto_cnt - p0, 0);
    check("glitch_state", db_estado_rx, 4'h0);

    // 10-bit-time break
    line = 1'b0;
    repeat (10 * BT) @(negedge clk);
    check("break_wait_high", db_estado_rx, 4'h6);
    check("break_erro", erro_cnt - e0, 1);
    line = 1'b1;
    repeat (5) @(negedge clk);
    check("break_idle", db_estado_rx, 4'h0);
    repeat (BT) @(negedge clk);
    send_str("#");
    check("break_resync", db_estado_parser, 4'h0);
    send_str("270,050#");
    repeat (5) @(negedge clk);
    check("break_erro_total", erro_cnt - e0, 1);
    check("break_pronto", pronto_cnt - p0, 1);
    check("break_angulo", angulo, 12'h270);
    check("break_dist", distancia, 12'h050);

    // Back-to-back frames with no idle gaps
    mark();
    send_str("111,222#333,444#555,666#");
    repeat (5) @(negedge clk);
    check("b2b_pronto", pronto_cnt - p0, 3);
    check("b2b_erro", erro_cnt - e0, 0);
    check("b2b_angulo", angulo, 12'h555);
    check("b2b_dist", distancia, 12'h666);

    // Reset during DATA of the pos-5 character
    send_str("001,0");
    line = 1'b0;
    repeat (BT + HT) @(negedge clk);
    check("mid_state_data", db_estado_rx, 4'h2);
    check("mid_parser_pos5", db_estado_parser, 4'h5);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_angulo", angulo, 12'h000);
    check("mid_rst_dist", distancia, 12'h000);
    check("mid_rst_state", db_estado_rx, 4'h0);
    check("mid_rst_parser", db_estado_parser, 4'h0);
    line = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (BT) @(negedge clk);
    mark();
    send_str("001,002#");
    repeat (5) @(negedge clk);
    check("post_rst_pronto", pronto_cnt - p0, 1);
    check("post_rst_angulo", angulo, 12'h001);
    check("post_rst_dist", distancia, 12'h002);

    check("pronto_erro_overlap", overlap_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
